ysyx_22050078_mem_arb: RTL and testbench

- Arbitrates one shared memory port between the IFU (read-only fetch) and the LSU (load/store with byte write mask).
- Sits between the two requesters and the memory interface.
- One transaction is outstanding at a time.
- Round-robin on ties, a per-transaction timeout, and registered response delivery.

---
 rtl/ysyx_22050078_mem_arb.sv | 179 +++++++++++++++++
 tb/tb_ysyx_22050078_mem_arb.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050078_mem_arb.sv
// Shares one memory port between the instruction fetch unit and the load/store unit.
// One transaction in flight; round-robin on ties, per-transaction timeout, registered responses.
module ysyx_22050078_mem_arb #(
   parameter int unsigned ADDR_W      = 64,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_ls_req,
   input  logic              i_ls_wen,
   input  logic [ADDR_W-1:0] i_ls_addr,
   input  logic [DATA_W-1:0] i_ls_wdata,
   input  logic [7:0]        i_ls_wmask,
   output logic              o_ls_gnt,
   output logic              o_ls_rvalid,
   output logic [DATA_W-1:0] o_ls_rdata,
   output logic              o_mem_valid,
   output logic              o_mem_wen,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [7:0]        o_mem_wmask,
   input  logic              i_mem_ready,
   input  logic              i_mem_rvalid,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_err,
   output logic              o_busy
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        wmask_q, wmask_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              ls_rvalid_q, ls_rvalid_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              err_q, err_d;

   logic              is_idle;
   logic              complete;
   logic              abort;
   logic              finish;
   logic [DATA_W-1:0] rsp_data;

   assign is_idle = (state_q == S_IDLE);

   // On a tie the requester that did not own the previous transaction wins.
   assign o_if_gnt = is_idle & i_if_req & (~i_ls_req | (last_q == OWN_LS));
   assign o_ls_gnt = is_idle & i_ls_req & (~i_if_req | (last_q == OWN_IF));

   assign complete = ((state_q == S_ISSUE) & i_mem_ready & i_mem_rvalid) |
                     ((state_q == S_WAIT) & i_mem_rvalid);
   assign abort    = ~is_idle & ~complete & (cnt_q == CNT_LAST);
   assign finish   = complete | abort;
   assign rsp_data = (complete & ~wen_q) ? i_mem_rdata : '0;

   assign o_busy      = ~is_idle;
   assign o_mem_valid = (state_q == S_ISSUE);
   assign o_mem_wen   = wen_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_wmask = wmask_q;
   assign o_if_rvalid = if_rvalid_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_ls_rvalid = ls_rvalid_q;
   assign o_ls_rdata  = ls_rdata_q;
   assign o_err       = err_q;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      if_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      ls_rvalid_d = 1'b0;
      ls_rdata_d  = ls_rdata_q;
      err_d       = abort;

      case (state_q)
         S_IDLE: begin
            if (o_ls_gnt) begin
               state_d = S_ISSUE;
               owner_d = OWN_LS;
               cnt_d   = '0;
               wen_d   = i_ls_wen;
               addr_d  = i_ls_addr;
               wdata_d = i_ls_wdata;
               wmask_d = i_ls_wen ? i_ls_wmask : 8'h00;
            end else if (o_if_gnt) begin
               state_d = S_ISSUE;
               owner_d = OWN_IF;
               cnt_d   = '0;
               wen_d   = 1'b0;
               addr_d  = i_if_addr;
               wdata_d = '0;
               wmask_d = 8'h00;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (finish) begin
               state_d = S_IDLE;
               last_d  = owner_q;
               if (owner_q == OWN_LS) begin
                  ls_rvalid_d = 1'b1;
                  ls_rdata_d  = rsp_data;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = rsp_data;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if ((state_q == S_ISSUE) && i_mem_ready) begin
                  state_d = S_WAIT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_LS;
         last_q      <= OWN_LS;
         cnt_q       <= '0;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= 8'h00;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rvalid_q <= 1'b0;
         ls_rdata_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rvalid_q <= ls_rvalid_d;
         ls_rdata_q  <= ls_rdata_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22050078_mem_arb.sv
// Directed bench for ysyx_22050078_mem_arb: transaction-level model checked every cycle,
// plus literal expectations per scenario.
module tb_ysyx_22050078_mem_arb;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TO = 8;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_if_req;
   logic [AW-1:0] i_if_addr;
   logic          o_if_gnt;
   logic          o_if_rvalid;
   logic [DW-1:0] o_if_rdata;
   logic          i_ls_req;
   logic          i_ls_wen;
   logic [AW-1:0] i_ls_addr;
   logic [DW-1:0] i_ls_wdata;
   logic [7:0]    i_ls_wmask;
   logic          o_ls_gnt;
   logic          o_ls_rvalid;
   logic [DW-1:0] o_ls_rdata;
   logic          o_mem_valid;
   logic          o_mem_wen;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic [7:0]    o_mem_wmask;
   logic          i_mem_ready;
   logic          i_mem_rvalid;
   logic [DW-1:0] i_mem_rdata;
   logic          o_err;
   logic          o_busy;

   always #5 i_clk = ~i_clk;

   ysyx_22050078_mem_arb #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_if_req     (i_if_req),
      .i_if_addr    (i_if_addr),
      .o_if_gnt     (o_if_gnt),
      .o_if_rvalid  (o_if_rvalid),
      .o_if_rdata   (o_if_rdata),
      .i_ls_req     (i_ls_req),
      .i_ls_wen     (i_ls_wen),
      .i_ls_addr    (i_ls_addr),
      .i_ls_wdata   (i_ls_wdata),
      .i_ls_wmask   (i_ls_wmask),
      .o_ls_gnt     (o_ls_gnt),
      .o_ls_rvalid  (o_ls_rvalid),
      .o_ls_rdata   (o_ls_rdata),
      .o_mem_valid  (o_mem_valid),
      .o_mem_wen    (o_mem_wen),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_mem_wmask  (o_mem_wmask),
      .i_mem_ready  (i_mem_ready),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata),
      .o_err        (o_err),
      .o_busy       (o_busy)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one pending request record plus the response registers.
   bit            m_busy, m_acc, m_own_ls, m_last_ls, m_wen;
   int            m_age;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [7:0]    m_wmask;
   bit            m_if_rv, m_ls_rv, m_err;
   logic [DW-1:0] m_if_rd, m_ls_rd;

   logic          e_if, e_ls, m_done, m_tmo;
   logic [DW-1:0] m_data;

   assign e_if   = !m_busy && i_if_req && (!i_ls_req || m_last_ls);
   assign e_ls   = !m_busy && i_ls_req && (!i_if_req || !m_last_ls);
   assign m_done = m_busy && i_mem_rvalid && (m_acc || i_mem_ready);
   assign m_tmo  = m_busy && !m_done && (m_age + 1 == TO);
   assign m_data = (m_done && !m_wen) ? i_mem_rdata : '0;

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_busy <= 0; m_acc <= 0; m_own_ls <= 1; m_last_ls <= 1; m_wen <= 0; m_age <= 0;
         m_addr <= '0; m_wdata <= '0; m_wmask <= '0;
         m_if_rv <= 0; m_ls_rv <= 0; m_err <= 0; m_if_rd <= '0; m_ls_rd <= '0;
      end else begin
         m_if_rv <= 0;
         m_ls_rv <= 0;
         m_err   <= 0;
         if (!m_busy) begin
            if (e_if || e_ls) begin
               m_busy   <= 1;
               m_acc    <= 0;
               m_age    <= 0;
               m_own_ls <= e_ls;
               m_addr   <= e_ls ? i_ls_addr : i_if_addr;
               m_wen    <= e_ls && i_ls_wen;
               m_wdata  <= e_ls ? i_ls_wdata : '0;
               m_wmask  <= (e_ls && i_ls_wen) ? i_ls_wmask : 8'h00;
            end
         end else if (m_done || m_tmo) begin
            m_busy    <= 0;
            m_last_ls <= m_own_ls;
            m_err     <= m_tmo;
            if (m_own_ls) begin
               m_ls_rv <= 1;
               m_ls_rd <= m_data;
            end else begin
               m_if_rv <= 1;
               m_if_rd <= m_data;
            end
         end else begin
            m_age <= m_age + 1;
            if (i_mem_ready) m_acc <= 1;
         end
      end
   end

   always @(negedge i_clk) begin
      check("if_gnt", o_if_gnt, e_if);
      check("ls_gnt", o_ls_gnt, e_ls);
      check("gnt_onehot", o_if_gnt & o_ls_gnt, 0);
      check("busy", o_busy, m_busy);
      check("mem_valid", o_mem_valid, m_busy && !m_acc);
      if (m_busy && !m_acc) begin
         check("mem_addr", o_mem_addr, m_addr);
         check("mem_wen", o_mem_wen, m_wen);
         check("mem_wmask", o_mem_wmask, m_wmask);
         if (m_wen) check("mem_wdata", o_mem_wdata, m_wdata);
      end
      check("if_rvalid", o_if_rvalid, m_if_rv);
      check("if_rdata", o_if_rdata, m_if_rd);
      check("ls_rvalid", o_ls_rvalid, m_ls_rv);
      check("ls_rdata", o_ls_rdata, m_ls_rd);
      check("err", o_err, m_err);
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   logic [1:0] seq [6];

   initial begin
      i_rst = 0; i_if_req = 0; i_if_addr = '0; i_ls_req = 0; i_ls_wen = 0; i_ls_addr = '0;
      i_ls_wdata = '0; i_ls_wmask = '0; i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
      #2 i_rst = 1;
      tick();
      tick();
      i_rst = 0;
      #3 check("reset_busy", o_busy, 0);
      check("reset_ls_rdata", o_ls_rdata, 0);

      // IFU alone, ready in ISSUE, rvalid two cycles later
      tick();
      i_if_req = 1; i_if_addr = 64'h8000_0000;
      #3 check("t1_gnt", o_if_gnt, 1);
      tick();
      i_if_req = 0; i_mem_ready = 1;
      #3 check("t1_valid", o_mem_valid, 1);
      check("t1_addr", o_mem_addr, 64'h8000_0000);
      tick();
      i_mem_ready = 0;
      #3 check("t1_valid_drop", o_mem_valid, 0);
      tick();
      i_mem_rvalid = 1; i_mem_rdata = 64'h1122_3344_5566_7788;
      #3 check("t1_no_early", o_if_rvalid, 0);
      tick();
      i_mem_rvalid = 0;
      #3 check("t1_rvalid", o_if_rvalid, 1);
      check("t1_rdata", o_if_rdata, 64'h1122_3344_5566_7788);
      tick();
      #3 check("t1_pulse_end", o_if_rvalid, 0);
      check("t1_rdata_hold", o_if_rdata, 64'h1122_3344_5566_7788);

      // Tie right after reset goes to IFU, then the held store
      i_rst = 1;
      tick();
      i_rst = 0;
      i_if_req = 1; i_if_addr = 64'h8000_0010;
      i_ls_req = 1; i_ls_wen = 1; i_ls_addr = 64'h8000_1000; i_ls_wdata = 64'hDEAD;
      i_ls_wmask = 8'h0F;
      #3 check("t2_if_gnt", o_if_gnt, 1);
      check("t2_ls_gnt", o_ls_gnt, 0);
      tick();
      i_if_req = 0; i_mem_ready = 1; i_mem_rvalid = 1; i_mem_rdata = 64'h0BAD;
      #3 check("t2_ls_wait", o_ls_gnt, 0);
      tick();
      i_mem_ready = 0; i_mem_rvalid = 0;
      #3 check("t2_if_rvalid", o_if_rvalid, 1);
      check("t2_ls_gnt_late", o_ls_gnt, 1);
      tick();
      i_ls_req = 0; i_mem_ready = 1;
      #3 check("t2_wen", o_mem_wen, 1);
      check("t2_wmask", o_mem_wmask, 8'h0F);
      check("t2_addr", o_mem_addr, 64'h8000_1000);
      check("t2_wdata", o_mem_wdata, 64'hDEAD);
      tick();
      i_mem_ready = 0;
      tick();
      i_mem_rvalid = 1; i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      i_mem_rvalid = 0;
      #3 check("t2_ls_rvalid", o_ls_rvalid, 1);
      check("t2_ls_rdata", o_ls_rdata, 0);

      // Both held for six transactions: strict alternation starting at IFU
      tick();
      i_if_req = 1; i_if_addr = 64'h8000_0100;
      i_ls_req = 1; i_ls_wen = 0; i_ls_addr = 64'h8000_4000; i_ls_wmask = 8'hFF;
      for (int i = 0; i < 6; i++) begin
         #3 seq[i] = {o_if_gnt, o_ls_gnt};
         tick();
         i_mem_ready = 1; i_mem_rvalid = 1; i_mem_rdata = 64'h100 + 64'(i);
         tick();
         i_mem_ready = 0; i_mem_rvalid = 0;
      end
      i_if_req = 0; i_ls_req = 0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t3_gnt%0d", i), 64'(seq[i]), (i % 2 == 0) ? 64'd2 : 64'd1);
      end
      #3 check("t3_ls_rdata", o_ls_rdata, 64'h105);

      // Memory stalls three cycles; fields stay put and IFU waits
      tick();
      i_ls_req = 1; i_ls_wen = 1; i_ls_addr = 64'h8000_2000; i_ls_wdata = 64'h55AA;
      i_ls_wmask = 8'hF0;
      #3 check("t4_gnt", o_ls_gnt, 1);
      tick();
      i_ls_req = 0; i_if_req = 1; i_if_addr = 64'h8000_0200;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) i_mem_ready = 1;
         #3 check($sformatf("t4_valid%0d", k), o_mem_valid, 1);
         check($sformatf("t4_addr%0d", k), o_mem_addr, 64'h8000_2000);
         check($sformatf("t4_wdata%0d", k), o_mem_wdata, 64'h55AA);
         check($sformatf("t4_wmask%0d", k), o_mem_wmask, 8'hF0);
         check($sformatf("t4_no_if_gnt%0d", k), o_if_gnt, 0);
         tick();
      end
      i_mem_ready = 0; i_mem_rvalid = 1; i_mem_rdata = 64'h4444;
      #3 check("t4_wait_no_gnt", o_if_gnt, 0);
      tick();
      i_mem_rvalid = 0;
      #3 check("t4_ls_rvalid", o_ls_rvalid, 1);
      check("t4_ls_rdata", o_ls_rdata, 0);
      check("t4_if_gnt", o_if_gnt, 1);
      tick();
      i_if_req = 0; i_mem_ready = 1; i_mem_rvalid = 1; i_mem_rdata = 64'hABC;
      tick();
      i_mem_ready = 0; i_mem_rvalid = 0;
      #3 check("t4_if_rdata", o_if_rdata, 64'hABC);

      // Timeout: memory never answers
      tick();
      i_if_req = 1; i_if_addr = 64'h8000_3000;
      #3 check("t5_gnt", o_if_gnt, 1);
      tick();
      i_if_req = 0;
      for (int k = 1; k <= TO; k++) begin
         #3 check($sformatf("t5_busy%0d", k), o_busy, 1);
         check($sformatf("t5_no_err%0d", k), o_err, 0);
         tick();
      end
      #3 check("t5_rvalid", o_if_rvalid, 1);
      check("t5_rdata", o_if_rdata, 0);
      check("t5_err", o_err, 1);
      check("t5_idle", o_busy, 0);
      tick();
      i_mem_rvalid = 1; i_mem_rdata = 64'h1234;
      #3 check("t5_err_end", o_err, 0);
      tick();
      i_mem_rvalid = 0;
      #3 check("t5_late_ignored", o_if_rvalid, 0);
      check("t5_rdata_kept", o_if_rdata, 0);

      // Reset while waiting on memory
      tick();
      i_ls_req = 1; i_ls_wen = 0; i_ls_addr = 64'h8000_5000;
      #3 check("t6_gnt", o_ls_gnt, 1);
      tick();
      i_ls_req = 0; i_mem_ready = 1;
      tick();
      i_mem_ready = 0;
      #3 check("t6_busy", o_busy, 1);
      tick();
      i_rst = 1;
      #1 check("t6_rst_busy", o_busy, 0);
      check("t6_rst_ls_rdata", o_ls_rdata, 0);
      check("t6_rst_ls_rvalid", o_ls_rvalid, 0);
      check("t6_rst_valid", o_mem_valid, 0);
      tick();
      i_rst = 0; i_mem_rvalid = 1; i_mem_rdata = 64'h777;
      tick();
      i_mem_rvalid = 0; i_if_req = 1; i_ls_req = 1;
      #3 check("t6_no_rvalid", o_ls_rvalid, 0);
      check("t6_tie_if", o_if_gnt, 1);
      check("t6_tie_ls", o_ls_gnt, 0);
      tick();
      i_if_req = 0; i_ls_req = 0; i_mem_ready = 1; i_mem_rvalid = 1; i_mem_rdata = 64'h999;
      tick();
      i_mem_ready = 0; i_mem_rvalid = 0;
      #3 check("t6_if_rdata", o_if_rdata, 64'h999);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
